uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8-bit Receiver. Runtime parity mode,
//  configurable data width/stop bits/oversampling, 3-sample majority vote, error flags and a
//  valid/ack output register. Sits between Baud_Rate_Module (baud_clk tick) and the consumer.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9, LSB first on the line
//  OVERSAMPLE  16  baud_clk ticks per bit, legal 8 or 16
//  STOP_BITS   1   stop bits checked, legal 1 or 2
//  SYNC_STAGES 2   rx_in synchroniser depth, >=2
// PORTS
//  sys_clk      in  1          system clock, all logic on posedge
//  reset        in  1          synchronous, active-low
//  baud_clk     in  1          1-sys_clk-wide enable pulse, OVERSAMPLE x baud rate
//  rx_in        in  1          serial line, idle high, asynchronous
//  parity_mode  in  2          00/11 none, 01 even, 10 odd; sampled at start-bit detect
//  data_ack     in  1          consumer has taken data_out (valid only while data_valid=1)
//  data_out     out DATA_BITS  received word
//  parity_bit   out 1          received parity bit (0 when mode none)
//  data_valid   out 1          data_out/flags hold a frame not yet acknowledged
//  busy         out 1          high from start detect until return to IDLE
//  parity_err   out 1          parity mismatch in held frame
//  frame_err    out 1          a stop-bit sample was 0 in held frame
//  overrun_err  out 1          held frame overwrote an unacknowledged one
//  break_det    out 1          held frame was all-zero data+parity with stop=0
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, tick/bit counters 0, synchroniser flops preset to 1.
//  Reset low mid-frame aborts the frame, no data_valid pulse; line re-acquired from IDLE.
//  All sampling happens only on sys_clk edges where baud_clk=1; tick_cnt runs 0..OVERSAMPLE-1.
//  Majority vote: samples at tick_cnt OS/2-1, OS/2, OS/2+1; bit value = 2-of-3.
//  FSM:
//   IDLE   : synced rx=0 on a tick -> START, tick_cnt=0, latch parity_mode, busy=1.
//   START  : at vote point start=1 -> IDLE (glitch rejected, busy=0); at tick OS-1 -> DATA.
//   DATA   : shift voted bit LSB first; after DATA_BITS bits -> PARITY (mode!=none) else STOP.
//   PARITY : vote parity bit; err = (mode even: ^data^p !=0 ; odd: ^data^p !=1).
//   STOP   : vote each stop bit; after vote of last stop bit -> completion, then IDLE
//            (no wait for bit end, so a start edge in the remaining half-bit is accepted).
//            If last stop=0 -> completion with frame_err, then WAIT_IDLE.
//   WAIT_IDLE: stay until synced rx=1 on a tick -> IDLE; busy=1 throughout.
//  Completion (1 sys_clk after the final vote tick): load data_out, parity_bit, all four flags,
//   data_valid=1. break_det = frame_err & data==0 & parity sample==0.
//  data_ack with data_valid=1 and no completion: data_valid<=0 next cycle; flags keep value.
//  Completion while data_valid=1 and no ack: overwrite, overrun_err=1.
//  Completion and ack same cycle: new frame loaded, data_valid stays 1, overrun_err=0.
//  data_ack with data_valid=0 is ignored.
//  Latency rx edge to START: SYNC_STAGES cycles + wait for next baud_clk tick.
// TESTING  (bench: Baud_Rate_Module baud_select=2'b10, 9600 baud, 50 MHz sys_clk)
//  1 DATA_BITS=8, even, send 0xAB p=1 stop=1 -> data_out=8'hAB, parity_bit=1, valid=1, all errs 0.
//  2 odd mode, send 0x55 with p=0 -> data_valid=1, parity_err=1; next frame 0x55 p=1 -> parity_err=0.
//  3 send 0x3C with stop=0, line high 2 bits later -> frame_err=1, busy held in WAIT_IDLE until rx=1.
//  4 hold rx=0 for 12 bit times -> data_out=0, frame_err=1, break_det=1, single data_valid pulse.
//  5 two back-to-back frames 0x11,0x22 with no data_ack -> data_out=8'h22, overrun_err=1;
//    repeat with ack on completion cycle -> overrun_err=0.
//  6 rx low pulse of 4 ticks -> START then IDLE, no data_valid; reset low mid DATA -> outputs 0,
//    following frame 0xA5 received correctly; DATA_BITS=7/STOP_BITS=2 variant receives 7'h5A.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Bundle of the UART receiver's line, configuration and consumer-side signals.
// The receiver sits on the slave modport; the bench/baud source/consumer on master.
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic                 baud_clk;
   logic                 rx_in;
   logic [1:0]           parity_mode;
   // data_valid/data_ack: a frame is handed over on a sys_clk edge where both are 1;
   // data_valid then drops unless a new frame completes on that same edge. An ack while
   // data_valid=0 has no effect, and the receiver never waits for the consumer.
   logic                 data_ack;
   logic [DATA_BITS-1:0] data_out;
   logic                 parity_bit;
   logic                 data_valid;
   logic                 busy;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun_err;
   logic                 break_det;
   logic [2:0]           state_dbg;

   modport slave (
      input  baud_clk, rx_in, parity_mode, data_ack,
      output data_out, parity_bit, data_valid, busy,
             parity_err, frame_err, overrun_err, break_det, state_dbg
   );

   modport master (
      output baud_clk, rx_in, parity_mode, data_ack,
      input  data_out, parity_bit, data_valid, busy,
             parity_err, frame_err, overrun_err, break_det, state_dbg
   );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled 3-sample majority vote, runtime parity mode,
// error flags and a valid/ack output register.
module uart_rx_param #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic           sys_clk,
   input  logic           reset,
   uart_rx_param_if.slave bus
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_V0   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_V1   = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_V2   = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [3:0]    NBITS  = 4'(DATA_BITS);
   localparam logic [3:0]    NSTOP  = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   ferr_q, ferr_d;
   logic [1:0]             mode_q, mode_d;
   logic [1:0]             vote_q, vote_d;
   logic                   cmpl_q, cmpl_d;

   logic [DATA_BITS-1:0]   data_out_q;
   logic                   pbit_q, valid_q, perr_q, frerr_q, oerr_q, brk_q;

   logic rx_s, tick, voted, par_en;
   logic at_v0, at_v1, at_v2, at_end;

   assign rx_s   = sync_q[SYNC_STAGES-1];
   assign tick   = bus.baud_clk;
   assign voted  = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
   assign par_en = (mode_q == 2'b01) || (mode_q == 2'b10);
   assign at_v0  = tick && (tick_cnt_q == T_V0);
   assign at_v1  = tick && (tick_cnt_q == T_V1);
   assign at_v2  = tick && (tick_cnt_q == T_V2);
   assign at_end = tick && (tick_cnt_q == T_LAST);

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      ferr_d     = ferr_q;
      mode_d     = mode_q;
      vote_d     = vote_q;
      cmpl_d     = 1'b0;

      if (tick) tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + 1'b1;
      if (at_v0) vote_d[0] = rx_s;
      if (at_v1) vote_d[1] = rx_s;

      case (state_q)
         S_IDLE: begin
            tick_cnt_d = '0;
            if (tick && !rx_s) begin
               state_d   = S_START;
               bit_cnt_d = '0;
               par_d     = 1'b0;
               ferr_d    = 1'b0;
               mode_d    = bus.parity_mode;
            end
         end
         S_START: begin
            if (at_v2 && voted) state_d = S_IDLE;
            else if (at_end)    state_d = S_DATA;
         end
         S_DATA: begin
            if (at_v2) begin
               shift_d   = {voted, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
            if (at_end && bit_cnt_q == NBITS) begin
               bit_cnt_d = '0;
               state_d   = par_en ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (at_v2)       par_d   = voted;
            else if (at_end) state_d = S_STOP;
         end
         S_STOP: begin
            // Completion fires on the last stop vote, not at bit end, so a start edge
            // arriving in the remaining half bit is not lost.
            if (at_v2) begin
               if (!voted) ferr_d = 1'b1;
               if (bit_cnt_q == NSTOP) begin
                  cmpl_d  = 1'b1;
                  state_d = voted ? S_IDLE : S_WAIT_IDLE;
               end
            end else if (at_end) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         S_WAIT_IDLE: begin
            tick_cnt_d = '0;
            if (tick && rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         sync_q     <= '1;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         ferr_q     <= 1'b0;
         mode_q     <= 2'b00;
         vote_q     <= 2'b00;
         cmpl_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.rx_in};
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         ferr_q     <= ferr_d;
         mode_q     <= mode_d;
         vote_q     <= vote_d;
         cmpl_q     <= cmpl_d;
      end
   end

   // Held-frame register: a completion always wins over an ack of the previous frame.
   always_ff @(posedge sys_clk) begin
      if (!reset) begin
         data_out_q <= '0;
         pbit_q     <= 1'b0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         frerr_q    <= 1'b0;
         oerr_q     <= 1'b0;
         brk_q      <= 1'b0;
      end else if (cmpl_q) begin
         data_out_q <= shift_q;
         pbit_q     <= par_en & par_q;
         perr_q     <= par_en & ((^shift_q ^ par_q) != (mode_q == 2'b10));
         frerr_q    <= ferr_q;
         oerr_q     <= valid_q & ~bus.data_ack;
         brk_q      <= ferr_q & (shift_q == '0) & ~par_q;
         valid_q    <= 1'b1;
      end else if (valid_q && bus.data_ack) begin
         valid_q    <= 1'b0;
      end
   end

   assign bus.data_out    = data_out_q;
   assign bus.parity_bit  = pbit_q;
   assign bus.data_valid  = valid_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.parity_err  = perr_q;
   assign bus.frame_err   = frerr_q;
   assign bus.overrun_err = oerr_q;
   assign bus.break_det   = brk_q;
   assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8-bit/1-stop instance and a 7-bit/2-stop instance,
// scoreboard queues checked by monitors on each data_valid/data_ack handover.
module tb_uart_rx_param;

   localparam int TICK_DIV = 4;
   localparam int BIT      = 16 * TICK_DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       baud = 1'b0;
   int         div = 0;
   logic       rx1 = 1'b1, rx2 = 1'b1;
   logic [1:0] pm1 = 2'b00, pm2 = 2'b01;
   logic       ack_auto = 1'b0, ack_man = 1'b0, ack2 = 1'b0;
   bit         auto_ack = 1'b1;

   int total = 0;
   int bad   = 0;
   logic [13:0] exp_q[$];
   logic [13:0] exp2_q[$];

   uart_rx_param_if #(.DATA_BITS(8)) bus1();
   uart_rx_param_if #(.DATA_BITS(7)) bus2();

   assign bus1.baud_clk    = baud;
   assign bus1.rx_in       = rx1;
   assign bus1.parity_mode = pm1;
   assign bus1.data_ack    = ack_auto | ack_man;
   assign bus2.baud_clk    = baud;
   assign bus2.rx_in       = rx2;
   assign bus2.parity_mode = pm2;
   assign bus2.data_ack    = ack2;

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .SYNC_STAGES(2)) dut1 (
      .sys_clk(clk), .reset(rst_n), .bus(bus1));
   uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .STOP_BITS(2), .SYNC_STAGES(2)) dut2 (
      .sys_clk(clk), .reset(rst_n), .bus(bus2));

   // clock / baud tick
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (div == TICK_DIV - 1) begin div <= 0; baud <= 1'b1; end
      else begin div <= div + 1; baud <= 1'b0; end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [13:0] mk(input logic [8:0] d, input logic pb, pe, fe, oe, bk);
      return {d, pb, pe, fe, oe, bk};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // driver tasks
   task automatic hold(input bit which, input logic v, input int ncyc);
      @(posedge clk); #1;
      if (which) rx2 = v; else rx1 = v;
      repeat (ncyc - 1) @(posedge clk);
   endtask

   task automatic send_gen(input bit which, input logic [8:0] d, input int nd, input bit pe,
                           input logic p, input logic [1:0] st, input int ns);
      hold(which, 1'b0, BIT);
      for (int i = 0; i < nd; i++) hold(which, d[i], BIT);
      if (pe) hold(which, p, BIT);
      for (int s = 0; s < ns; s++) hold(which, st[s], BIT);
   endtask

   task automatic send1(input logic [7:0] d, input bit pe, input logic p);
      send_gen(1'b0, {1'b0, d}, 8, pe, p, 2'b11, 1);
   endtask

   // consumers
   initial forever begin
      @(negedge clk);
      if (auto_ack && bus1.data_valid) begin
         #1 ack_auto = 1'b1;
         @(posedge clk); #1 ack_auto = 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (bus2.data_valid) begin
         #1 ack2 = 1'b1;
         @(posedge clk); #1 ack2 = 1'b0;
      end
   end

   // scoreboard monitors: compare at each handover
   initial forever begin
      logic [13:0] got;
      @(negedge clk); #2;
      if (rst_n && bus1.data_valid && bus1.data_ack) begin
         got = {1'b0, bus1.data_out, bus1.parity_bit, bus1.parity_err, bus1.frame_err,
                bus1.overrun_err, bus1.break_det};
         if (exp_q.size() == 0) chk("dut1_unexpected_frame", 32'(got), 32'h3fff_0000);
         else chk("dut1_frame", 32'(got), 32'(exp_q.pop_front()));
      end
   end

   initial forever begin
      logic [13:0] got;
      @(negedge clk); #2;
      if (rst_n && bus2.data_valid && bus2.data_ack) begin
         got = {2'b0, bus2.data_out, bus2.parity_bit, bus2.parity_err, bus2.frame_err,
                bus2.overrun_err, bus2.break_det};
         if (exp2_q.size() == 0) chk("dut2_unexpected_frame", 32'(got), 32'h3fff_0000);
         else chk("dut2_frame", 32'(got), 32'(exp2_q.pop_front()));
      end
   end

   initial begin
      bit ok;

      // reset
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_data_out", bus1.data_out, 0);
      chk("rst_flags", {bus1.data_valid, bus1.busy, bus1.parity_bit, bus1.parity_err,
                        bus1.frame_err, bus1.overrun_err, bus1.break_det}, 0);
      chk("rst_state", bus1.state_dbg, 0);
      chk("rst_dut2", {bus2.data_out, bus2.data_valid, bus2.busy}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      hold(1'b0, 1'b1, 2 * BIT);

      // even parity, clean frame
      pm1 = 2'b01;
      exp_q.push_back(mk(9'h0AB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      send1(8'hAB, 1'b1, 1'b1);
      hold(1'b0, 1'b1, BIT);

      // odd parity: wrong then right parity bit
      pm1 = 2'b10;
      exp_q.push_back(mk(9'h055, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      send1(8'h55, 1'b1, 1'b0);
      exp_q.push_back(mk(9'h055, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      send1(8'h55, 1'b1, 1'b1);
      hold(1'b0, 1'b1, BIT);

      // framing error, receiver parks until the line goes high
      pm1 = 2'b00;
      exp_q.push_back(mk(9'h03C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      send_gen(1'b0, 9'h03C, 8, 1'b0, 1'b0, 2'b00, 1);
      hold(1'b0, 1'b0, BIT);
      @(negedge clk);
      chk("wait_idle_busy", bus1.busy, 1);
      chk("wait_idle_state", bus1.state_dbg, 5);
      hold(1'b0, 1'b1, BIT);
      @(negedge clk);
      chk("wait_idle_exit", bus1.busy, 0);
      chk("flags_hold_after_ack", {bus1.data_valid, bus1.frame_err}, 2'b01);

      // break: line low for 12 bit times
      exp_q.push_back(mk(9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      hold(1'b0, 1'b0, 12 * BIT);
      hold(1'b0, 1'b1, 2 * BIT);
      @(negedge clk);
      chk("break_idle", bus1.busy, 0);

      // overrun: two frames, no ack
      auto_ack = 1'b0;
      exp_q.push_back(mk(9'h022, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      send1(8'h11, 1'b0, 1'b0);
      send1(8'h22, 1'b0, 1'b0);
      @(negedge clk);
      chk("overrun_valid", {bus1.data_valid, bus1.overrun_err}, 2'b11);
      auto_ack = 1'b1;
      hold(1'b0, 1'b1, BIT);

      // same pair, ack lands on the completion cycle of the second frame
      auto_ack = 1'b0;
      exp_q.push_back(mk(9'h011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(9'h022, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      send1(8'h11, 1'b0, 1'b0);
      fork
         send1(8'h22, 1'b0, 1'b0);
         begin
            ok = 1'b0;
            for (int i = 0; i < 3 * BIT; i++) begin
               @(negedge clk);
               if (bus1.busy) begin ok = 1'b1; break; end
            end
            chk("p2_busy_rise", ok, 1);
            ok = 1'b0;
            for (int i = 0; i < 12 * BIT; i++) begin
               @(negedge clk);
               if (!bus1.busy) begin ok = 1'b1; break; end
            end
            chk("p2_busy_fall", ok, 1);
            #1 ack_man = 1'b1;
            @(posedge clk); #1 ack_man = 1'b0;
         end
      join
      @(negedge clk);
      chk("p2_no_overrun", {bus1.data_valid, bus1.overrun_err}, 2'b10);
      auto_ack = 1'b1;
      hold(1'b0, 1'b1, 2 * BIT);

      // short glitch: start detected then rejected
      hold(1'b0, 1'b0, 4 * TICK_DIV);
      @(negedge clk);
      chk("glitch_start", bus1.busy, 1);
      hold(1'b0, 1'b1, 3 * BIT);
      @(negedge clk);
      chk("glitch_reject", {bus1.busy, bus1.data_valid}, 0);

      // reset in the middle of the data bits
      hold(1'b0, 1'b0, BIT);
      hold(1'b0, 1'b1, BIT);
      hold(1'b0, 1'b0, BIT);
      hold(1'b0, 1'b1, BIT);
      @(negedge clk);
      chk("mid_data_state", bus1.state_dbg, 2);
      @(posedge clk); #1 rst_n = 1'b0; rx1 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("mid_reset_outputs", {bus1.data_out, bus1.data_valid, bus1.busy, bus1.parity_bit,
                                bus1.parity_err, bus1.frame_err, bus1.overrun_err,
                                bus1.break_det}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      hold(1'b0, 1'b1, 2 * BIT);
      exp_q.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      send1(8'hA5, 1'b0, 1'b0);
      hold(1'b0, 1'b1, BIT);

      // 7 data bits, even parity, 2 stop bits
      exp2_q.push_back(mk(9'h05A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      send_gen(1'b1, 9'h05A, 7, 1'b1, 1'b0, 2'b11, 2);
      hold(1'b1, 1'b1, 2 * BIT);

      // final report
      @(negedge clk);
      chk("dut1_queue_drained", 32'(exp_q.size()), 0);
      chk("dut2_queue_drained", 32'(exp2_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
